spi_frame_master: RTL and testbench
===================================

// Module: spi_frame_master
// PURPOSE
// - SPI master (mode 0: CPOL=0, CPHA=0, MSB first) exchanging one fixed 32-bit full-duplex frame per start request.
// - Acts as the initiator end of the FPGA<->STM link, whose FPGA side is the slave_top responder.
// - Used for the on-board loopback/HIL bench against slave_top and as the board-to-board link master.
// - tx frame carries motor commands; rx frame carries the enemy report.
// PARAMETERS
// - FRAME_W  32  bits per frame; fixed by the link format (package constant, do not override)
// - CLK_DIV  50  clk cycles per SCLK half-period; legal range >= 4 (1 MHz SCLK at 100 MHz)
// - GAP_CYC  8   minimum clk cycles that cs stays high between frames; legal range >= 1
// PORTS
// - clk       in   1        system clock
// - reset     in   1        asynchronous, active-low reset
// - start     in   1        frame request; sampled only while busy=0
// - tx_frame  in   FRAME_W  command frame; latched on the accepted start
// - busy      out  1        high from the accepted start through the end of the inter-frame gap
// - done      out  1        1-cycle pulse in the cycle cs returns high
// - rx_frame  out  FRAME_W  last received frame; updated in the same cycle done pulses
// - sclk      out  1        SPI clock; idles low
// - mosi      out  1        master data out
// - miso      in   1        slave data in; asynchronous to clk
// - cs        out  1        chip select, active-low
// BEHAVIOUR
// - Reset (reset=0): state IDLE; outputs cs=1, sclk=0, mosi=0, busy=0, done=0; rx_frame=0; all counters=0.
// - State IDLE: start=1 at clk edge T -> latch tx_frame into the shift register; busy=1 at T+1.
// - State LO: entered at T+1 with cs=0 and mosi=tx bit31.
//   - Hold for CLK_DIV cycles, then go to HI with sclk=1.
// - State HI: hold for CLK_DIV cycles.
//   - In the last HI cycle, shift the synchronised miso into the rx shift register (LSB in).
//   - Not last bit: go to LO with sclk=0 and present the next tx bit on mosi in the same cycle.
//   - Last bit (bit counter = FRAME_W-1): go to HOLD with sclk=0.
// - State HOLD: CLK_DIV cycles with cs=0, sclk=0. At exit: cs=1, rx_frame <= rx shift register, done=1 for one cycle.
// - State GAP: GAP_CYC cycles with cs=1, busy=1; then IDLE with busy=0.
//   - The next start is accepted in the first cycle busy=0.
// - Timing: cs low for (2*FRAME_W+1)*CLK_DIV cycles; start-to-done latency = 1 + (2*FRAME_W+1)*CLK_DIV cycles.
// - miso passes through a 2-flop synchroniser before sampling.
//   - Sampling at the end of HI gives >= CLK_DIV-2 cycles of margin after the slave's output change on the falling edge.
// - Bit counter: 0..FRAME_W-1, no wrap. Divider counter: 0..CLK_DIV-1, reloaded on every state change.
// - start while busy=1: ignored. tx_frame changes mid-frame: no effect (latched copy is used).
// - start held high continuously: back-to-back frames with exactly GAP_CYC cs-high cycles between them.
// - reset asserted mid-frame: cs=1 and sclk=0 immediately (asynchronous). The partial frame is discarded: no done pulse, rx_frame=0.
// - mosi is held at the last bit's value in HOLD and driven to 0 in GAP/IDLE.
// STRUCTURE
// - spi_link_pkg (shared with slave_top and its users):
//   - localparam FRAME_W=32.
//   - typedef enum {IDLE,LO,HI,HOLD,GAP} spim_state_t.
//   - typedef struct packed spi_cmd_t: motor_x[7:0], motor_y[6:0], etc[16:0] (MSB first; bit16=stm_state[2], bit13=laser_fire_flag).
//   - typedef struct packed spi_rpt_t: enemy_x[9:0], enemy_y[8:0], etc[12:0] (bit12=red_detected, bit11=target_on_box, bit10=laser_fire_complete).
// - Sub-module spi_half_tick: CLK_DIV half-period counter with load/tick.
//   - All other logic (FSM, shift registers, synchroniser) stays in this module.
// TESTING
// - Reset: hold reset=0 -> cs=1, sclk=0, mosi=0, busy=0, rx_frame=0; release -> no activity until start.
// - Single frame (CLK_DIV=4, GAP_CYC=8): tx=32'hA5C3_0F1E, slave model returns 32'h1234_5678.
//   - Bench captures 32 bits A5C30F1E on mosi at sclk rises.
//   - rx_frame=32'h1234_5678 and done pulses once, 1+65*4=261 cycles after start.
// - start pulsed 100 cycles into a frame with tx=32'hFFFF_FFFF -> ignored; the current frame completes unchanged and no second frame follows.
// - start held high for 3 frames -> three cs-low windows of 260 cycles each; cs high for exactly 8 cycles between them; 3 done pulses.
// - reset=0 after the 10th sclk rise -> cs=1, sclk=0 in the same cycle; no done pulse.
//   - After release, a fresh frame with tx=32'h0000_0001 completes correctly.
// - Integration with slave_top:
//   - tx = spi_cmd_t{motor_x=200, motor_y=100, etc=0} -> mortor_xdata=200, mortor_ydata=100, mosi_valid asserted.
//   - Slave enemy_x=320, enemy_y=240, miso_etc bit12=1 -> rx_frame decodes to enemy_x=320, enemy_y=240, red_detected=1.

Source files
------------

// File: rtl/spi_link_pkg.sv
// Shared FPGA<->STM link definitions: frame width, master FSM states and frame layouts.
// Used by spi_frame_master and the slave_top responder side.
package spi_link_pkg;
    localparam int FRAME_W = 32;
    localparam int BIT_W   = $clog2(FRAME_W);

    typedef enum logic [2:0] {IDLE, LO, HI, HOLD, GAP} spim_state_t;

    // Command frame (master -> slave); etc[16]=stm_state[2], etc[13]=laser_fire_flag.
    typedef struct packed {
        logic [7:0]  motor_x;
        logic [6:0]  motor_y;
        logic [16:0] etc;
    } spi_cmd_t;

    // Report frame (slave -> master).
    typedef struct packed {
        logic [9:0]  enemy_x;
        logic [8:0]  enemy_y;
        logic [12:0] etc;
    } spi_rpt_t;

    localparam int RPT_RED_DETECTED    = 12;
    localparam int RPT_TARGET_ON_BOX   = 11;
    localparam int RPT_LASER_COMPLETE  = 10;
    localparam int CMD_LASER_FIRE_FLAG = 13;
endpackage

// File: rtl/spi_frame_master_if.sv
// Host-side request/response bus of the SPI frame master.
// slave = the master block serving requests; master = the requester driving start/tx_frame.
interface spi_frame_master_if
    import spi_link_pkg::*;
();
    logic               start;
    logic [FRAME_W-1:0] tx_frame;
    logic               busy;
    logic               done;
    logic [FRAME_W-1:0] rx_frame;

    modport slave  (input  start, tx_frame, output busy, done, rx_frame);
    modport master (output start, tx_frame, input  busy, done, rx_frame);
endinterface

// File: rtl/spi_half_tick.sv
// SCLK half-period counter: tick on the last of DIV enabled cycles, load restarts at 0.
// Latency: tick is combinational on the count; no backpressure.
module spi_half_tick #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       cnt <= '0;
        else if (load)    cnt <= '0;
        else if (en)      cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 master: one FRAME_W-bit full-duplex frame per accepted start, MSB first.
// start->done is 1+(2*FRAME_W+1)*CLK_DIV cycles; start is ignored while busy (no queueing).
module spi_frame_master
    import spi_link_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int GAP_CYC = 8
) (
    input  logic              clk,
    input  logic              reset,
    spi_frame_master_if.slave bus,
    output logic              sclk,
    output logic              mosi,
    output logic              cs,
    input  logic              miso
);
    localparam int GW = $clog2(GAP_CYC + 1);

    spim_state_t        state, state_nxt;
    logic               tick, accept, shift, sample, finish;
    logic [BIT_W-1:0]   bit_cnt;
    logic [GW-1:0]      gap_cnt;
    logic [FRAME_W-1:0] tx_sh, rx_sh, rx_q;
    logic               busy_q, done_q;
    logic               miso_meta, miso_s;

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rx_frame = rx_q;

    spi_half_tick #(.DIV(CLK_DIV)) u_half_tick (
        .clk   (clk),
        .reset (reset),
        .load  (state_nxt != state),
        .en    (state == LO || state == HI || state == HOLD),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // The IDLE cycle in which start is accepted is itself a cs-high cycle, so the
    // GAP state lasts GAP_CYC-1 cycles to keep back-to-back frames GAP_CYC apart.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        shift     = 1'b0;
        sample    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                state_nxt = LO;
                accept    = 1'b1;
            end
            LO:   if (tick) state_nxt = HI;
            HI:   if (tick) begin
                sample = 1'b1;
                if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                    state_nxt = HOLD;
                end else begin
                    state_nxt = LO;
                    shift     = 1'b1;
                end
            end
            HOLD: if (tick) begin
                finish    = 1'b1;
                state_nxt = (GAP_CYC > 1) ? GAP : IDLE;
            end
            GAP:  if (gap_cnt == GW'(GAP_CYC - 2)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miso_meta <= 1'b0;
            miso_s    <= 1'b0;
        end else begin
            miso_meta <= miso;
            miso_s    <= miso_meta;
        end
    end

    // Pin outputs are registered from the next state so sclk/cs/mosi never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk    <= 1'b0;
            cs      <= 1'b1;
            mosi    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rx_q    <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            sclk    <= (state_nxt == HI);
            cs      <= (state_nxt == IDLE) || (state_nxt == GAP);
            busy_q  <= (state_nxt != IDLE);
            done_q  <= finish;
            gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
            if (accept) begin
                tx_sh   <= bus.tx_frame;
                mosi    <= bus.tx_frame[FRAME_W-1];
                bit_cnt <= '0;
            end else if (shift) begin
                tx_sh   <= tx_sh << 1;
                mosi    <= tx_sh[FRAME_W-2];
                bit_cnt <= bit_cnt + BIT_W'(1);
            end else if (finish) begin
                mosi    <= 1'b0;
            end
            if (sample) rx_sh <= {rx_sh[FRAME_W-2:0], miso_s};
            if (finish) rx_q  <= rx_sh;
        end
    end
endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: directed frames against a mode-0 slave model, scoreboard on done.
module tb_spi_frame_master;
    import spi_link_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int GAP_CYC = 8;
    localparam int LAT     = 261;
    localparam int CS_LOW  = 260;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sclk, mosi, cs;
    logic miso = 1'b0;

    spi_frame_master_if bus();

    spi_frame_master #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .sclk  (sclk),
        .mosi  (mosi),
        .cs    (cs),
        .miso  (miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_rx_q[$];
    logic [31:0] exp_mosi_q[$];
    int          exp_gap_q[$];
    logic [31:0] slave_rpt_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Mode-0 slave: drives MSB on cs fall, next bit on each sclk fall, captures mosi on sclk rise.
    logic [31:0] s_rpt = '0;
    logic [31:0] s_cap = '0;
    int          s_idx = 0;
    int          s_ncap = 0;
    bit          s_active = 1'b0;

    always @(negedge cs or posedge cs or posedge sclk or negedge sclk) begin
        if (cs !== 1'b0) begin
            s_active = 1'b0;
        end else if (!s_active) begin
            s_active = 1'b1;
            if (slave_rpt_q.size() != 0) s_rpt = slave_rpt_q.pop_front();
            else                         s_rpt = '0;
            s_idx  = 31;
            s_cap  = '0;
            s_ncap = 0;
            miso   = s_rpt[31];
        end else if (sclk === 1'b1) begin
            s_cap = {s_cap[30:0], mosi};
            s_ncap++;
        end else if (s_idx > 0) begin
            s_idx--;
            miso = s_rpt[s_idx];
        end
    end

    // Monitor / scoreboard.
    int cyc = 0;
    int acc_cyc = 0;
    int lo_cnt = 0;
    int hi_cnt = 0;
    int done_cnt = 0;
    logic prev_cs = 1'b1;
    bit gap_armed = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.start === 1'b1 && bus.busy === 1'b0) acc_cyc = cyc;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (exp_rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done pulse at cycle %0d, expected none", cyc);
                end else begin
                    check("rx_frame", bus.rx_frame, exp_rx_q.pop_front());
                    check("mosi_frame", s_cap, exp_mosi_q.pop_front());
                    check("mosi_bits", s_ncap, 32);
                    check("latency", cyc - acc_cyc, LAT);
                end
            end
            if (cs === 1'b0 && prev_cs === 1'b1) begin
                if (gap_armed) check("cs_gap", hi_cnt, exp_gap_q.pop_front());
                lo_cnt = 0;
            end
            if (cs === 1'b1 && prev_cs === 1'b0) begin
                check("cs_low", lo_cnt, CS_LOW);
                gap_armed = (exp_gap_q.size() != 0);
                hi_cnt = 0;
            end
            if (cs === 1'b0) lo_cnt++;
            else             hi_cnt++;
        end else begin
            lo_cnt    = 0;
            hi_cnt    = 0;
            gap_armed = 1'b0;
        end
        prev_cs = cs;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [31:0] tx, input logic [31:0] rpt,
                             input logic [31:0] exp_mosi, input logic [31:0] exp_rx);
        slave_rpt_q.push_back(rpt);
        exp_mosi_q.push_back(exp_mosi);
        exp_rx_q.push_back(exp_rx);
        bus.tx_frame = tx;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.busy === 1'b0) break;
        end
        check(name, 32'(bus.busy), 32'd0);
    endtask

    logic [31:0] b2b_rpt [3] = '{32'h1111_2222, 32'h8001_7FFE, 32'h0F0F_F0F0};
    spi_cmd_t cmd, got_cmd;
    spi_rpt_t rpt, got_rpt;

    initial begin
        bus.start    = 1'b0;
        bus.tx_frame = '0;
        repeat (3) step();
        check("reset_cs",   32'(cs), 32'd1);
        check("reset_sclk", 32'(sclk), 32'd0);
        check("reset_mosi", 32'(mosi), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_rx",   bus.rx_frame, 32'h0);

        reset = 1'b1;
        repeat (20) step();
        check("idle_cs",   32'(cs), 32'd1);
        check("idle_sclk", 32'(sclk), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Single frame.
        run_frame(32'hA5C3_0F1E, 32'h1234_5678, 32'hA5C3_0F1E, 32'h1234_5678);
        wait_idle("single_idle", 600);
        check("single_done_cnt", done_cnt, 1);

        // start during a frame is ignored; latched tx is used.
        run_frame(32'h0F0F_55AA, 32'hDEAD_BEEF, 32'h0F0F_55AA, 32'hDEAD_BEEF);
        repeat (100) step();
        bus.tx_frame = 32'hFFFF_FFFF;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        wait_idle("ignore_idle", 600);
        repeat (300) step();
        check("ignore_done_cnt", done_cnt, 2);
        check("ignore_busy", 32'(bus.busy), 32'd0);

        // start held high: three back-to-back frames.
        exp_gap_q.push_back(8);
        exp_gap_q.push_back(8);
        for (int k = 0; k < 3; k++) begin
            slave_rpt_q.push_back(b2b_rpt[k]);
            exp_rx_q.push_back(b2b_rpt[k]);
            exp_mosi_q.push_back(32'h3C3C_9669);
        end
        bus.tx_frame = 32'h3C3C_9669;
        bus.start    = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (done_cnt == 4 && cs === 1'b0) break;
        end
        bus.start = 1'b0;
        check("b2b_third_started", 32'(cs), 32'd0);
        wait_idle("b2b_idle", 600);
        repeat (50) step();
        check("b2b_done_cnt", done_cnt, 5);

        // Reset mid-frame after the 10th sclk rise.
        slave_rpt_q.push_back(32'hCAFE_F00D);
        bus.tx_frame = 32'h1234_5678;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (s_ncap >= 10) break;
            step();
        end
        check("abort_sclk_high", 32'(sclk), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_cs",   32'(cs), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_rx",   bus.rx_frame, 32'h0);
        repeat (3) step();
        reset = 1'b1;
        repeat (10) step();
        check("abort_no_done", done_cnt, 5);
        run_frame(32'h0000_0001, 32'h8000_0001, 32'h0000_0001, 32'h8000_0001);
        wait_idle("post_abort_idle", 600);
        check("post_abort_done_cnt", done_cnt, 6);

        // Link-format frames: cmd {200,100,0} and report {320,240,red_detected}.
        cmd = '{motor_x: 8'd200, motor_y: 7'd100, etc: 17'd0};
        rpt = '{enemy_x: 10'd320, enemy_y: 9'd240, etc: 13'h1000};
        run_frame(cmd, rpt, 32'hC8C8_0000, 32'h501E_1000);
        wait_idle("link_idle", 600);
        got_cmd = s_cap;
        got_rpt = bus.rx_frame;
        check("link_motor_x", 32'(got_cmd.motor_x), 32'd200);
        check("link_motor_y", 32'(got_cmd.motor_y), 32'd100);
        check("link_enemy_x", 32'(got_rpt.enemy_x), 32'd320);
        check("link_enemy_y", 32'(got_rpt.enemy_y), 32'd240);
        check("link_red_detected", 32'(got_rpt.etc[RPT_RED_DETECTED]), 32'd1);
        check("link_done_cnt", done_cnt, 7);
        check("scoreboard_drained", exp_rx_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
